// File: rtl/retry_window_pkg.sv
`default_nettype none
// ============================================================================
// Module   : retry_window_pkg
// Brief    : Shared slot type and pointer helper for the retry window.
// Revision : 1.0 - initial release
// ============================================================================

// Slot layout parametrised by payload and retry-counter width, so modules with
// non-default widths build the same struct shape locally.
`define RETRY_SLOT_T(DW, RW) struct packed { logic occupied; logic [(DW)-1:0] data; logic [(RW)-1:0] rcnt; }

package retry_window_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_RCNT_WIDTH = 2;

  // Slot type at the default widths.
  typedef `RETRY_SLOT_T(DEFAULT_DATA_WIDTH, DEFAULT_RCNT_WIDTH) retry_slot_t;

  // Wrapping increment of the allocation pointer.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/retry_window_slot.sv
`default_nettype none
// ============================================================================
// Module   : retry_window_slot
// Brief    : One replay-window entry: occupancy flag, payload, retry count.
// Revision : 1.0 - initial release
// ============================================================================
module retry_window_slot
  import retry_window_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int RcntWidth = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 free_i,
  input  logic                 inc_i,
  output logic                 occupied_o,
  output logic [DataWidth-1:0] data_o,
  output logic [RcntWidth-1:0] rcnt_o
);

  typedef `RETRY_SLOT_T(DataWidth, RcntWidth) slot_t;

  slot_t slot_q, slot_d;

  // Next slot contents: allocation only targets a free slot, so it never
  // competes with a meaningful free or count increment.
  always_comb begin
    slot_d = slot_q;
    if (wr_i) begin
      slot_d.occupied = 1'b1;
      slot_d.data     = wr_data_i;
      slot_d.rcnt     = '0;
    end else if (free_i) begin
      slot_d.occupied = 1'b0;
    end else if (inc_i) begin
      slot_d.rcnt = slot_q.rcnt + RcntWidth'(1);
    end
  end

  // Slot register; reset (active high) discards the stored item.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign occupied_o = slot_q.occupied;
  assign data_o     = slot_q.data;
  assign rcnt_o     = slot_q.rcnt;

endmodule

`default_nettype wire

// File: rtl/retry_window_start.sv
`default_nettype none
// ============================================================================
// Module   : retry_window_start
// Brief    : Retry source with an in-order multi-slot replay window, bounded
//            per-item retry budget and drop reporting.
// Revision : 1.0 - initial release
// ============================================================================
module retry_window_start
  import retry_window_pkg::*;
#(
  parameter int DataWidth  = 8,
  parameter int IDSize     = 2,
  parameter int MaxRetries = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic [IDSize-1:0]    id_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  input  logic [IDSize-1:0]    retry_id_i,
  input  logic                 retry_valid_i,
  output logic                 retry_ready_o,
  input  logic [IDSize-1:0]    commit_id_i,
  input  logic                 commit_valid_i,
  output logic                 fail_o,
  output logic [IDSize-1:0]    fail_id_o,
  output logic [IDSize:0]      occupancy_o
);

  localparam int DEPTH  = 2 ** IDSize;
  localparam int RCNT_W = $clog2(MaxRetries + 1);
  localparam int OCC_W  = IDSize + 1;

  logic                 occ [DEPTH];
  logic [DataWidth-1:0] sdata [DEPTH];
  logic [RCNT_W-1:0]    rcnt [DEPTH];

  logic [IDSize-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occupancy_q, occupancy_d;
  logic              fail_q;
  logic [IDSize-1:0] fail_id_q;

  logic full, conflict, retry_live, retry_can, drop, commit_hit, alloc, inc;

  // Handshake qualifiers. Full depends only on registered slot state, so a
  // commit to the head slot opens allocation one cycle later.
  always_comb begin
    full       = occ[wr_ptr_q];
    conflict   = commit_valid_i && (commit_id_i == retry_id_i);
    retry_live = retry_valid_i && occ[retry_id_i] && !conflict;
    retry_can  = retry_live && (rcnt[retry_id_i] < RCNT_W'(MaxRetries));
    drop       = retry_live && !retry_can;
    commit_hit = commit_valid_i && occ[commit_id_i];
    alloc      = !retry_valid_i && !full && valid_i && ready_i;
    inc        = retry_can && ready_i;
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      retry_window_slot #(
        .DataWidth (DataWidth),
        .RcntWidth (RCNT_W)
      ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_i       (alloc && (wr_ptr_q == IDSize'(i))),
        .wr_data_i  (data_i),
        .free_i     ((commit_hit && (commit_id_i == IDSize'(i))) ||
                     (drop && (retry_id_i == IDSize'(i)))),
        .inc_i      (inc && (retry_id_i == IDSize'(i))),
        .occupied_o (occ[i]),
        .data_o     (sdata[i]),
        .rcnt_o     (rcnt[i])
      );
    end
  endgenerate

  // Downstream mux: a pending retry wins over new data; reset forces all
  // handshake outputs low.
  always_comb begin
    valid_o       = 1'b0;
    ready_o       = 1'b0;
    retry_ready_o = 1'b0;
    data_o        = data_i;
    id_o          = wr_ptr_q;
    if (!rst_n) begin
      if (retry_valid_i) begin
        if (retry_can) begin
          valid_o       = 1'b1;
          data_o        = sdata[retry_id_i];
          id_o          = retry_id_i;
          retry_ready_o = ready_i;
        end else begin
          retry_ready_o = 1'b1;
        end
      end else if (!full) begin
        valid_o = valid_i;
        ready_o = ready_i;
      end
    end
  end

  // Pointer advance and occupancy bookkeeping; commit and drop always hit
  // distinct slots, so up to two frees can land in one cycle.
  always_comb begin
    wr_ptr_d    = alloc ? IDSize'(next_ptr(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
    occupancy_d = occupancy_q + OCC_W'(alloc) - OCC_W'(commit_hit) - OCC_W'(drop);
  end

  // Window state and drop reporting registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q    <= '0;
      occupancy_q <= '0;
      fail_q      <= 1'b0;
      fail_id_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      occupancy_q <= occupancy_d;
      fail_q      <= drop;
      if (drop) fail_id_q <= retry_id_i;
    end
  end

  assign fail_o      = fail_q;
  assign fail_id_o   = fail_id_q;
  assign occupancy_o = occupancy_q;

endmodule

`default_nettype wire

// File: tb/tb_retry_window_start.sv
`default_nettype none
// ============================================================================
// Module   : tb_retry_window_start
// Brief    : Self-checking bench for retry_window_start with a slot-level
//            behavioural reference model, directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_retry_window_start;

  localparam int DW    = 8;
  localparam int IDW   = 2;
  localparam int MAXR  = 3;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [DW-1:0]  data_i = '0;
  logic           valid_i = 1'b0;
  logic           ready_o;
  logic [DW-1:0]  data_o;
  logic [IDW-1:0] id_o;
  logic           valid_o;
  logic           ready_i = 1'b0;
  logic [IDW-1:0] retry_id_i = '0;
  logic           retry_valid_i = 1'b0;
  logic           retry_ready_o;
  logic [IDW-1:0] commit_id_i = '0;
  logic           commit_valid_i = 1'b0;
  logic           fail_o;
  logic [IDW-1:0] fail_id_o;
  logic [IDW:0]   occupancy_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: window contents as plain arrays.
  bit m_occ  [DEPTH];
  int m_data [DEPTH];
  int m_rcnt [DEPTH];
  int m_wp;
  bit m_fail;
  int m_fail_id;

  retry_window_start #(.DataWidth(DW), .IDSize(IDW), .MaxRetries(MAXR)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .data_o         (data_o),
    .id_o           (id_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .retry_id_i     (retry_id_i),
    .retry_valid_i  (retry_valid_i),
    .retry_ready_o  (retry_ready_o),
    .commit_id_i    (commit_id_i),
    .commit_valid_i (commit_valid_i),
    .fail_o         (fail_o),
    .fail_id_o      (fail_id_o),
    .occupancy_o    (occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += m_occ[i];
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_occ[i] = 0; m_data[i] = 0; m_rcnt[i] = 0;
    end
    m_wp = 0; m_fail = 0; m_fail_id = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model.
  task automatic cyc(input bit v, input int d, input bit rdy, input bit rv, input int rid,
                     input bit cv, input int cid);
    bit ev, er, err, conflict, do_alloc, nf;
    int ed, eid;
    @(negedge clk);
    valid_i = v; data_i = DW'(d); ready_i = rdy;
    retry_valid_i = rv; retry_id_i = IDW'(rid);
    commit_valid_i = cv; commit_id_i = IDW'(cid);
    #1;
    ev = 0; er = 0; err = 0; ed = d; eid = m_wp;
    conflict = cv && (cid == rid);
    if (rv) begin
      if (m_occ[rid] && !conflict && m_rcnt[rid] < MAXR) begin
        ev = 1; ed = m_data[rid]; eid = rid; err = rdy;
      end else begin
        err = 1;
      end
    end else if (!m_occ[m_wp]) begin
      ev = v; er = rdy;
    end
    chk_val("ready_o", 32'(ready_o), 32'(er));
    chk_val("valid_o", 32'(valid_o), 32'(ev));
    chk_val("retry_ready_o", 32'(retry_ready_o), 32'(err));
    if (ev) begin
      chk_val("data_o", 32'(data_o), 32'(ed));
      chk_val("id_o", 32'(id_o), 32'(eid));
    end
    chk_val("fail_o", 32'(fail_o), 32'(m_fail));
    chk_val("fail_id_o", 32'(fail_id_o), 32'(m_fail_id));
    chk_val("occupancy_o", 32'(occupancy_o), 32'(m_count()));
    // Model update from pre-cycle state.
    do_alloc = !rv && !m_occ[m_wp] && v && rdy;
    nf = 0;
    if (rv && m_occ[rid] && !conflict) begin
      if (m_rcnt[rid] < MAXR) begin
        if (rdy) m_rcnt[rid]++;
      end else begin
        m_occ[rid] = 0; nf = 1; m_fail_id = rid;
      end
    end
    if (cv) m_occ[cid] = 0;
    if (do_alloc) begin
      m_occ[m_wp] = 1; m_data[m_wp] = d; m_rcnt[m_wp] = 0;
      m_wp = (m_wp + 1) % DEPTH;
    end
    m_fail = nf;
  endtask

  task automatic idle();
    cyc(0, 0, 1, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse in the middle of a cycle with busy inputs.
  task automatic do_reset();
    @(negedge clk);
    valid_i = 1; ready_i = 1; retry_valid_i = 1; retry_id_i = '0;
    commit_valid_i = 0;
    #2 rst_n = 1'b1;
    #1;
    chk_val("rst_ready_o", 32'(ready_o), 0);
    chk_val("rst_valid_o", 32'(valid_o), 0);
    chk_val("rst_retry_ready_o", 32'(retry_ready_o), 0);
    chk_val("rst_occupancy", 32'(occupancy_o), 0);
    chk_val("rst_fail_o", 32'(fail_o), 0);
    chk_val("rst_fail_id", 32'(fail_id_o), 0);
    m_reset();
    @(negedge clk);
    valid_i = 0; ready_i = 0; retry_valid_i = 0; commit_valid_i = 0;
    rst_n = 1'b0;
  endtask

  initial begin
    m_reset();
    #12;
    do_reset();

    // Fill the window, then release the head slot.
    cyc(1, 'h11, 1, 0, 0, 0, 0);
    cyc(1, 'h22, 1, 0, 0, 0, 0);
    cyc(1, 'h33, 1, 0, 0, 0, 0);
    cyc(1, 'h44, 1, 0, 0, 0, 0);
    cyc(1, 'h55, 1, 0, 0, 0, 0);
    chk_val("full_ready", 32'(ready_o), 0);
    chk_val("full_occupancy", 32'(occupancy_o), 4);
    cyc(1, 'h55, 1, 0, 0, 1, 0);
    chk_val("release_same_cycle_ready", 32'(ready_o), 0);
    cyc(1, 'h55, 1, 0, 0, 0, 0);
    chk_val("wrap_ready", 32'(ready_o), 1);
    chk_val("wrap_id", 32'(id_o), 0);

    do_reset();

    // Single replay, then exhaustion of slot 0.
    cyc(1, 'hA5, 1, 0, 0, 0, 0);
    cyc(1, 'h5A, 1, 1, 0, 0, 0);
    chk_val("replay_data", 32'(data_o), 'hA5);
    chk_val("replay_id", 32'(id_o), 0);
    cyc(1, 'h5A, 1, 0, 0, 0, 0);
    chk_val("after_replay_id", 32'(id_o), 1);
    chk_val("after_replay_data", 32'(data_o), 'h5A);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk_val("replay2_data", 32'(data_o), 'hA5);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk_val("replay3_data", 32'(data_o), 'hA5);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk_val("exhaust_valid", 32'(valid_o), 0);
    chk_val("exhaust_retry_ready", 32'(retry_ready_o), 1);
    idle();
    chk_val("exhaust_fail", 32'(fail_o), 1);
    chk_val("exhaust_fail_id", 32'(fail_id_o), 0);
    chk_val("exhaust_occupancy", 32'(occupancy_o), 1);
    idle();
    chk_val("fail_single_pulse", 32'(fail_o), 0);

    // Commit and retry of the same slot in one cycle.
    cyc(1, 'h77, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 2, 1, 2);
    chk_val("conflict_retry_ready", 32'(retry_ready_o), 1);
    chk_val("conflict_valid", 32'(valid_o), 0);
    idle();
    chk_val("conflict_no_fail", 32'(fail_o), 0);
    chk_val("conflict_occupancy", 32'(occupancy_o), 1);

    // Stale commit to a free slot.
    cyc(0, 0, 1, 0, 0, 1, 3);
    idle();
    chk_val("stale_occupancy", 32'(occupancy_o), 1);

    // Three slots occupied, then reset mid-stream.
    cyc(1, 'h81, 1, 0, 0, 0, 0);
    cyc(1, 'h82, 1, 0, 0, 0, 0);
    idle();
    chk_val("pre_reset_occupancy", 32'(occupancy_o), 3);
    do_reset();
    cyc(1, 'h99, 1, 0, 0, 0, 0);
    chk_val("post_reset_id", 32'(id_o), 0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) do_reset();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3),
          $urandom_range(0, 2) == 0, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
